// File: rtl/multimode_counter.sv
// WIDTH-bit counter with run-time selectable binary up/down, Johnson and Gray modes,
// synchronous load, count enable and a combinational terminal-count flag.
module multimode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [1:0]       mode_act
);

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_JOHNSON = 2'b10;
  localparam logic [1:0] MODE_GRAY    = 2'b11;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_shadow;
  logic [1:0]       r_mode_act;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [1:0]       w_mode_nxt;
  logic [WIDTH-1:0] w_shadow_inc;
  logic [WIDTH-1:0] w_term;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_shadow_inc = r_shadow + ONE;

  always_comb begin
    w_q_nxt      = r_q;
    w_shadow_nxt = r_shadow;
    w_mode_nxt   = r_mode_act;
    if (mode != r_mode_act) begin
      // A mode switch restarts from zero and swallows any load/enable on this edge.
      w_mode_nxt   = mode;
      w_q_nxt      = '0;
      w_shadow_nxt = '0;
    end else if (load) begin
      w_q_nxt      = load_val;
      w_shadow_nxt = (r_mode_act == MODE_GRAY) ? gray2bin(load_val) : load_val;
    end else if (en) begin
      case (r_mode_act)
        MODE_UP: begin
          w_q_nxt      = r_q + ONE;
          w_shadow_nxt = r_q + ONE;
        end
        MODE_DOWN: begin
          w_q_nxt      = r_q - ONE;
          w_shadow_nxt = r_q - ONE;
        end
        MODE_JOHNSON: begin
          w_q_nxt = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
        end
        default: begin
          w_shadow_nxt = w_shadow_inc;
          w_q_nxt      = bin2gray(w_shadow_inc);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= '0;
      r_shadow   <= '0;
      r_mode_act <= MODE_UP;
    end else begin
      r_q        <= w_q_nxt;
      r_shadow   <= w_shadow_nxt;
      r_mode_act <= w_mode_nxt;
    end
  end

  always_comb begin
    w_term = ALL_ONES;
    case (r_mode_act)
      MODE_UP:      w_term = ALL_ONES;
      MODE_DOWN:    w_term = '0;
      MODE_JOHNSON: w_term = MSB_ONLY;
      default:      w_term = MSB_ONLY;
    endcase
  end

  assign q        = r_q;
  assign mode_act = r_mode_act;
  assign tc       = en & (r_q == w_term);

endmodule

// File: doc/multimode_counter.md
# multimode_counter

Parametrised WIDTH-bit counter that generalises the team's fixed 4-bit ripple, synchronous and Johnson up-counters into one block with run-time mode select. It supports binary up, binary down, Johnson and Gray-code counting, plus synchronous load, count enable and a terminal-count flag. It drops into any datapath that previously instantiated one of the 4-bit counters, and the existing counter bench drives it through `clk` and `rst`.

## Interface
- `WIDTH`, default 4, counter width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: count enable; advances one step per rising edge while high.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: value captured on `load`.
- `mode` input 2: counting mode.
  - 00: binary up.
  - 01: binary down.
  - 10: Johnson.
  - 11: Gray up.
- `q` output WIDTH: registered count in the active mode's encoding.
- `tc` output 1: terminal count, `en` AND (`q` equals the active mode's terminal state).
- `mode_act` output 2: registered mode currently in effect.

## Operation
- **Reset.** While `rst` is high, immediately and regardless of `clk`:
  - `q` = 0.
  - internal binary shadow = 0.
  - `mode_act` = 00.
  - `tc` = 0.
- **Priority at each rising edge**, highest first:
  1. Mode change.
  2. Load.
  3. Count.
  4. Hold.
- **Mode change.** If `mode` differs from `mode_act`:
  - `mode_act` takes the new `mode` value.
  - `q` and the shadow clear to 0.
  - `load` and `en` are ignored on that edge.
- **Load.** When `load` is high, `q` takes `load_val`; `en` is ignored.
  - In Gray mode, `load_val` is treated as a Gray code; the shadow receives its Gray-to-binary conversion.
  - In Johnson mode, `load_val` is loaded unchanged. Illegal Johnson patterns are not corrected and continue under the shift rule.
- **Count** (`en` high, no load, no mode change):
  - Up: `q` ← `q`+1, modulo 2^WIDTH.
  - Down: `q` ← `q`−1, modulo 2^WIDTH.
  - Johnson: `q` ← {`q`[WIDTH-2:0], ~`q`[WIDTH-1]}. Period is 2·WIDTH.
  - Gray: shadow ← shadow+1; `q` ← next_shadow ^ (next_shadow >> 1). Exactly one bit of `q` changes per step, including at wrap.
- **Hold.** `en` low leaves `q` and `mode_act` unchanged.
- **Terminal states:**
  - Up: all ones.
  - Down: all zeros.
  - Johnson: MSB only (e.g. 1000).
  - Gray: Gray(2^WIDTH−1), i.e. MSB only.
- **Wrap-around.** The step after the terminal state returns to the mode's start state, with no stall and no extra cycle:
  - 0 for Up, Johnson and Gray.
  - All ones for Down.

## Timing
- **`q` latency:** one clock edge from a sampled `en`, `load` or `mode` to the updated `q`. No combinational path from inputs to `q`.
- **`tc` is combinational** from `en`, `q` and `mode_act`. It is high during the cycle in which the next enabled edge wraps the counter.
  - Cascading: connect `tc` of stage n to `en` of stage n+1.
- **`mode_act`** updates on the same edge as the clear caused by a mode change.
- **Reset deassertion:** the first count occurs on the first rising edge after `rst` falls, provided `en` is high. Deassertion must meet recovery time to `clk`. Reset asserted mid-count clears asynchronously, with no partial update.
- **Shadow coherence:** the Gray shadow stays coherent with `q` across all load, clear and reset events.

## Test plan
- **Reset.** Assert `rst` mid-count in Up mode at `q`=0101, between edges.
  - `q`=0000 and `tc`=0 before the next edge.
  - After release, count resumes 0001, 0010.
- **Up wrap** (WIDTH=4). Load 1110, then `en`=1 for three edges.
  - `q`: 1111 (`tc`=1), 0000, 0001.
  - `tc` is high only while `q`=1111.
- **Down mode.** From reset, select `mode`=01 (one clear edge), then `en`=1.
  - `tc`=1 at `q`=0000.
  - `q`: 1111, 1110, 1101.
- **Johnson** (WIDTH=4). From 0000, count 9 edges.
  - `q`: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
  - `tc`=1 only at 1000.
- **Gray.** Count 16 edges from 0000.
  - Every transition flips exactly one bit.
  - `q`=1000 asserts `tc`, then wraps to 0000.
  - Load `load_val`=0110 (binary 4); next step gives 0111.
- **Simultaneous events.**
  - `mode` change with `load`=1 and `en`=1 on the same edge: `q`=0 and `mode_act` updated; the load is discarded.
  - `load`=1 with `en`=1: `q`=`load_val` exactly.
  - Repeat with WIDTH=8 in Up mode: 255 → 0 wrap.
